// File: rtl/decodificador_instrucao_fila.sv
// Instruction decoder feeding a small FIFO of decoded fields and error flags.
// Accept/pop on valid/ready; flush clears the queue; counters track accepts.
module decodificador_instrucao_fila #(
    parameter int INSTR_W    = 32,
    parameter int OPCODE_W   = 4,
    parameter int IDX_W      = 3,
    parameter int DADO_W     = 16,
    parameter int ID_W       = 2,
    parameter int MATRIZ_DIM = 5,
    parameter int OPCODE_MAX = 8,
    parameter int DEPTH      = 4,
    parameter int CNT_W      = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [INSTR_W-1:0]           instrucao,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [OPCODE_W-1:0]          opcode,
    output logic [IDX_W-1:0]             linha,
    output logic [IDX_W-1:0]             coluna,
    output logic [DADO_W-1:0]            dado,
    output logic [ID_W-1:0]              id_matriz,
    output logic                         erro_opcode,
    output logic                         erro_indice,
    output logic [$clog2(DEPTH+1)-1:0]   ocupacao,
    output logic [CNT_W-1:0]             cnt_instr,
    output logic [CNT_W-1:0]             cnt_erro
);

    localparam int OCC_W   = $clog2(DEPTH+1);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int OP_LSB  = INSTR_W - OPCODE_W;
    localparam int LIN_LSB = OP_LSB - IDX_W;
    localparam int COL_LSB = LIN_LSB - IDX_W;
    localparam int DAD_LSB = COL_LSB - DADO_W;
    localparam int ID_LSB  = DAD_LSB - ID_W;
    localparam logic [OCC_W-1:0] CHEIO = OCC_W'(DEPTH);

    if (INSTR_W < OPCODE_W + 2*IDX_W + DADO_W + ID_W) begin : g_chk_w
        $error("INSTR_W too small for the field layout");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_chk_d
        $error("DEPTH must be a power of two and at least 2");
    end
    if (MATRIZ_DIM > (1 << IDX_W)) begin : g_chk_m
        $error("MATRIZ_DIM does not fit in IDX_W bits");
    end

    typedef struct packed {
        logic [OPCODE_W-1:0] op;
        logic [IDX_W-1:0]    lin;
        logic [IDX_W-1:0]    col;
        logic [DADO_W-1:0]   dad;
        logic [ID_W-1:0]     id;
        logic                eo;
        logic                ei;
    } ent_t;

    ent_t             mem [DEPTH];
    ent_t             novo;
    ent_t             head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;

    always_comb begin
        novo     = '0;
        novo.op  = instrucao[OP_LSB  +: OPCODE_W];
        novo.lin = instrucao[LIN_LSB +: IDX_W];
        novo.col = instrucao[COL_LSB +: IDX_W];
        novo.dad = instrucao[DAD_LSB +: DADO_W];
        novo.id  = instrucao[ID_LSB  +: ID_W];
        novo.eo  = int'(novo.op) > OPCODE_MAX;
        novo.ei  = (int'(novo.lin) >= MATRIZ_DIM) ||
                   (int'(novo.col) >= MATRIZ_DIM);
    end

    assign in_ready  = (ocupacao != CHEIO);
    assign out_valid = (ocupacao != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign head      = mem[rd_ptr];

    // Everything is gated so an empty queue presents all-zero fields.
    assign opcode      = out_valid ? head.op  : '0;
    assign linha       = out_valid ? head.lin : '0;
    assign coluna      = out_valid ? head.col : '0;
    assign dado        = out_valid ? head.dad : '0;
    assign id_matriz   = out_valid ? head.id  : '0;
    assign erro_opcode = out_valid && head.eo;
    assign erro_indice = out_valid && head.ei;

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= novo;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ocupacao  <= '0;
            cnt_instr <= '0;
            cnt_erro  <= '0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ocupacao <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (cnt_instr != '1) begin
                    cnt_instr <= cnt_instr + 1'b1;
                end
                if ((novo.eo || novo.ei) && cnt_erro != '1) begin
                    cnt_erro <= cnt_erro + 1'b1;
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                ocupacao <= ocupacao + 1'b1;
            end else if (pop && !push) begin
                ocupacao <= ocupacao - 1'b1;
            end
        end
    end

endmodule
